// File: rtl/serial_rx_ctrl.sv
// Asynchronous serial receive controller with a one-entry valid/ready output buffer.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module serial_rx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 651,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 m_clock,
    input  logic                 p_reset,
    input  logic                 RDX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef SERIAL_RX_PARITY_EN
    output logic                 parity_err,
`endif
    input  logic                 err_clr
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned NW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] NBIT_LAST = NW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
`ifdef SERIAL_RX_PARITY_EN
        , StParity
`endif
    } state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rxs_q, rxs_prev_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NW-1:0]        nbit_q, nbit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 deliver_q, deliver_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 set_frame, set_overrun;
    logic                 start_det;
`ifdef SERIAL_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
    logic                 set_parity;
`endif

    assign start_det = ~rxs_q & rxs_prev_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        nbit_d    = nbit_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        set_frame = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        set_parity = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_det) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // A line back high at mid start bit is a glitch, not a frame.
                if (cnt_q == CNT_HALF) begin
                    state_d = rxs_q ? StIdle : StData;
                    nbit_d  = '0;
                end
            end
            StData: begin
                if (cnt_q == CNT_FULL) begin
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    nbit_d  = nbit_q + 1'b1;
                    cnt_d   = '0;
                    if (nbit_q == NBIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            StParity: begin
                if (cnt_q == CNT_FULL) begin
                    par_bad_d  = ^{shift_q, rxs_q};
                    set_parity = par_bad_d;
                    state_d    = StStop;
                end
            end
`endif
            StStop: begin
                if (cnt_q == CNT_FULL) begin
                    state_d = StIdle;
                    if (rxs_q) begin
`ifdef SERIAL_RX_PARITY_EN
                        deliver_d = ~par_bad_q;
`else
                        deliver_d = 1'b1;
`endif
                    end else begin
                        set_frame = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Output buffer: a delivery into a full, unconsumed buffer is dropped.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        set_overrun = 1'b0;
        if (deliver_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                set_overrun = 1'b1;
            end
        end
        frame_err_d = set_frame | (frame_err_q & ~err_clr);
        overrun_d   = set_overrun | (overrun_q & ~err_clr);
`ifdef SERIAL_RX_PARITY_EN
        parity_err_d = set_parity | (parity_err_q & ~err_clr);
`endif
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            nbit_q      <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= RDX;
            rxs_q       <= rx_meta_q;
            rxs_prev_q  <= rxs_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbit_q      <= nbit_d;
            shift_q     <= shift_d;
            deliver_q   <= deliver_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q != StIdle);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Scoreboard bench for serial_rx_ctrl: directed frames, expected bytes queued at stimulus time.
`timescale 1ns/1ps
module tb_serial_rx_ctrl;

    localparam int CPB = 16;
`ifdef SERIAL_RX_PARITY_EN
    localparam int EXP_LAT = 8 + 10 * 16 + 1;
`else
    localparam int EXP_LAT = 8 + 9 * 16 + 1;
`endif

    logic       m_clock = 1'b0;
    logic       p_reset = 1'b1;
    logic       RDX = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       err_clr = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] sb_q[$];

    int cyc = 0, start_cyc = 0, valid_cyc = 0, vrun = 0, last_vlen = 0;
    logic busy_prev = 1'b0, valid_prev = 1'b0;

    serial_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .m_clock   (m_clock),
        .p_reset   (p_reset),
        .RDX       (RDX),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef SERIAL_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .err_clr   (err_clr)
    );

    always #5 m_clock = ~m_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one frame bit-by-bit; limit truncates it (line returns high).
    task automatic drive_frame(input logic [7:0] b, input logic stop, input logic par_flip,
                               input int limit);
        logic [10:0] bits;
        int nb;
`ifdef SERIAL_RX_PARITY_EN
        bits = {stop, (^b) ^ par_flip, b, 1'b0};
        nb = 11;
`else
        bits = {par_flip, stop, b, 1'b0};
        nb = 10;
`endif
        for (int i = 0; i < nb * CPB && i < limit; i++) begin
            @(posedge m_clock); #1;
            RDX = bits[i / CPB];
        end
        @(posedge m_clock); #1;
        RDX = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge m_clock);
        #1;
    endtask

    // Monitor: latency bookkeeping plus scoreboard pop on every handshake.
    initial begin
        forever begin
            @(negedge m_clock);
            cyc++;
            if (!p_reset) begin
                if (busy && !busy_prev) start_cyc = cyc;
                if (rx_valid && !valid_prev) valid_cyc = cyc;
                if (rx_valid) vrun++;
                else if (valid_prev) begin
                    last_vlen = vrun;
                    vrun = 0;
                end
                if (rx_valid && rx_ready) begin
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: got byte 0x%0h, expected none", rx_data);
                    end else begin
                        logic [7:0] e;
                        e = sb_q.pop_front();
                        if (rx_data !== e) begin
                            n_fail++;
                            $display("FAIL sb_data: got 0x%0h, expected 0x%0h", rx_data, e);
                        end
                    end
                end
            end
            busy_prev = busy;
            valid_prev = rx_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        idle(4);
        p_reset = 1'b0;
        @(negedge m_clock);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);

        seen = 1'b0;
        repeat (200) begin
            @(negedge m_clock);
            if (busy || rx_valid || frame_err || overrun) seen = 1'b1;
        end
        check("idle_quiet", seen, 0);

        // Good frame, consumer always ready.
        sb_q.push_back(8'hA5);
        drive_frame(8'hA5, 1'b1, 1'b0, 1000);
        idle(10);
        check("latency_start_to_valid", valid_cyc - start_cyc, EXP_LAT);
        check("valid_pulse_len", last_vlen, 1);
        check("a5_no_frame_err", frame_err, 0);
        check("a5_no_overrun", overrun, 0);

        // 5-cycle glitch must be rejected at the half-bit sample.
        repeat (5) begin
            @(posedge m_clock); #1;
            RDX = 1'b0;
        end
        @(posedge m_clock); #1;
        RDX = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge m_clock);
            if (busy) seen = 1'b1;
        end
        check("glitch_entered_start", seen, 1);
        check("glitch_back_idle", busy, 0);
        check("glitch_no_valid", rx_valid, 0);
        check("glitch_no_frame_err", frame_err, 0);

        // Bad stop bit.
        drive_frame(8'h3C, 1'b0, 1'b0, 1000);
        idle(10);
        @(negedge m_clock);
        check("framing_err_set", frame_err, 1);
        check("framing_no_valid", rx_valid, 0);
        @(posedge m_clock); #1;
        err_clr = 1'b1;
        @(posedge m_clock); #1;
        err_clr = 1'b0;
        @(negedge m_clock);
        check("framing_err_cleared", frame_err, 0);

        // Overrun: second byte dropped while buffer full.
        rx_ready = 1'b0;
        sb_q.push_back(8'h11);
        drive_frame(8'h11, 1'b1, 1'b0, 1000);
        drive_frame(8'h22, 1'b1, 1'b0, 1000);
        idle(5);
        @(negedge m_clock);
        check("ovr_rx_data_kept", rx_data, 8'h11);
        check("ovr_rx_valid", rx_valid, 1);
        check("ovr_flag", overrun, 1);
        @(posedge m_clock); #1;
        rx_ready = 1'b1;
        @(negedge m_clock);
        @(negedge m_clock);
        check("ovr_valid_falls", rx_valid, 0);
        check("ovr_data_holds", rx_data, 8'h11);
        @(posedge m_clock); #1;
        err_clr = 1'b1;
        @(posedge m_clock); #1;
        err_clr = 1'b0;
        @(negedge m_clock);
        check("ovr_cleared", overrun, 0);

        // Reset in the middle of data bit 4, then a clean frame.
        drive_frame(8'h5A, 1'b1, 1'b0, 5 * CPB + 8);
        @(posedge m_clock); #1;
        p_reset = 1'b1;
        @(posedge m_clock); #1;
        p_reset = 1'b0;
        @(negedge m_clock);
        check("midreset_busy", busy, 0);
        check("midreset_no_valid", rx_valid, 0);
        check("midreset_no_flags", {frame_err, overrun}, 2'b00);
        idle(40);
        sb_q.push_back(8'h5A);
        drive_frame(8'h5A, 1'b1, 1'b0, 1000);
        idle(10);
        check("after_reset_no_flags", {frame_err, overrun}, 2'b00);

`ifdef SERIAL_RX_PARITY_EN
        // 0x07 has three ones, so a parity bit of 0 is wrong.
        drive_frame(8'h07, 1'b1, 1'b1, 1000);
        idle(10);
        check("parity_err_set", parity_err, 1);
        check("parity_no_frame_err", frame_err, 0);
        check("parity_no_valid", rx_valid, 0);
`endif

        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
